// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   pipe_ctrl_state_e : controller FSM state, 2-bit encoding (exported on state_op)
//   StgIf/StgId/StgEx : bit positions of the IF, ID and EX stages in stall/flush vectors
//   shadow_entry_t    : one in-flight instruction tracked by the hazard scoreboard
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1
    } pipe_ctrl_state_e;

    localparam int unsigned StgIf = 0;
    localparam int unsigned StgId = 1;
    localparam int unsigned StgEx = 2;

    // Widest register address a shadow entry can hold; narrower REG_AW values are
    // zero-extended into it so the struct stays parameter-independent.
    localparam int unsigned RegAwMax = 8;
    typedef logic [RegAwMax-1:0] shadow_rd_t;

    typedef struct packed {
        logic       valid;
        shadow_rd_t rd;
        logic       we;
        logic       is_load;
    } shadow_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between Decode/pipeline and the hazard controller.
//   master : Decode/pipeline side, drives ID operands, redirect and memory handshake,
//            receives the stall/flush vectors, FSM state and stall-cycle counter
//   slave  : the hazard controller itself
interface pipe_hazard_ctrl_if #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned HCNT_W     = 16
) ();

    logic                  id_valid_ip;
    logic [REG_AW-1:0]     id_rs1_ip;
    logic                  id_rs1_used_ip;
    logic [REG_AW-1:0]     id_rs2_ip;
    logic                  id_rs2_used_ip;
    logic [REG_AW-1:0]     id_rd_ip;
    logic                  id_rd_we_ip;
    logic                  id_is_load_ip;
    logic                  ex_redirect_ip;
    logic                  mem_req_ip;
    logic                  mem_gnt_ip;
    logic [NUM_STAGES-1:0] stall_op;
    logic [NUM_STAGES-1:0] flush_op;
    logic [1:0]            state_op;
    logic [HCNT_W-1:0]     hazard_cnt_op;

    modport master (
        output id_valid_ip, id_rs1_ip, id_rs1_used_ip, id_rs2_ip, id_rs2_used_ip,
               id_rd_ip, id_rd_we_ip, id_is_load_ip, ex_redirect_ip, mem_req_ip, mem_gnt_ip,
        input  stall_op, flush_op, state_op, hazard_cnt_op
    );

    modport slave (
        input  id_valid_ip, id_rs1_ip, id_rs1_used_ip, id_rs2_ip, id_rs2_used_ip,
               id_rd_ip, id_rd_we_ip, id_is_load_ip, ex_redirect_ip, mem_req_ip, mem_gnt_ip,
        output stall_op, flush_op, state_op, hazard_cnt_op
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_scoreboard.sv
// Shadow of in-flight destination registers (stages EX..WB) plus RAW / load-use
// comparators against the instruction currently in ID.
//   clock, reset     : core clock, synchronous active-high reset
//   advance          : shadow shifts one stage this cycle
//   ex_bubble        : EX receives a bubble instead of the ID instruction
//   id_*             : ID instruction fields
//   hazard           : ID must be held this cycle
module pipe_hazard_ctrl_hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned REG_AW     = 5,
    parameter bit          FWD_EN     = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              advance,
    input  logic              ex_bubble,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_rs1_used,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    output logic              hazard
);

    // Index 0 is EX, last index is WB.
    localparam int unsigned NumShadow = NUM_STAGES - 2;

    shadow_entry_t shadow_q [NumShadow];
    shadow_entry_t id_entry;

    always_comb begin
        id_entry         = '0;
        id_entry.valid   = id_valid;
        id_entry.rd      = shadow_rd_t'(id_rd);
        id_entry.we      = id_rd_we;
        id_entry.is_load = id_is_load;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NumShadow; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (advance) begin
            shadow_q[0] <= ex_bubble ? '0 : id_entry;
            for (int i = 1; i < NumShadow; i++) begin
                shadow_q[i] <= shadow_q[i-1];
            end
        end
    end

    function automatic logic rd_hit(shadow_entry_t e, logic [REG_AW-1:0] rs, logic used);
        return used && (rs != '0) && e.valid && e.we && (e.rd == shadow_rd_t'(rs));
    endfunction

    always_comb begin
        hazard = 1'b0;
        if (FWD_EN) begin
            // Forwarding covers everything except a load result needed right behind it.
            hazard = shadow_q[0].is_load &&
                     (rd_hit(shadow_q[0], id_rs1, id_rs1_used) ||
                      rd_hit(shadow_q[0], id_rs2, id_rs2_used));
        end else begin
            // No forwarding and no register-file write-through: wait until the
            // producer has left WB.
            for (int i = 0; i < NumShadow; i++) begin
                hazard = hazard ||
                         rd_hit(shadow_q[i], id_rs1, id_rs1_used) ||
                         rd_hit(shadow_q[i], id_rs2, id_rs2_used);
            end
        end
        hazard = hazard && id_valid;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: generates per-stage stall and flush vectors
// from data hazards, data-memory grant waits and EX-resolved redirects.
//   clock, reset : core clock, synchronous active-high reset
//   bus (slave)  : ID operands, redirect, memory req/gnt in; stall_op, flush_op,
//                  state_op (debug) and saturating stall-cycle counter out
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned REG_AW     = 5,
    parameter bit          FWD_EN     = 1'b1,
    parameter int unsigned MEM_STAGE  = 3,
    parameter int unsigned HCNT_W     = 16
) (
    input logic               clock,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    if (MEM_STAGE <= StgEx || MEM_STAGE >= NUM_STAGES - 1 || REG_AW > RegAwMax) begin : g_bad_cfg
        $error("pipe_hazard_ctrl: unsupported MEM_STAGE/NUM_STAGES/REG_AW combination");
    end

    pipe_ctrl_state_e      state_q, state_d;
    logic                  pend_q, pend_d;
    logic [HCNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] stall, flush;
    logic                  hazard, advance, ex_bubble, mem_stuck;

    pipe_hazard_ctrl_hazard_scoreboard #(
        .NUM_STAGES (NUM_STAGES),
        .REG_AW     (REG_AW),
        .FWD_EN     (FWD_EN)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .advance     (advance),
        .ex_bubble   (ex_bubble),
        .id_valid    (bus.id_valid_ip),
        .id_rs1      (bus.id_rs1_ip),
        .id_rs1_used (bus.id_rs1_used_ip),
        .id_rs2      (bus.id_rs2_ip),
        .id_rs2_used (bus.id_rs2_used_ip),
        .id_rd       (bus.id_rd_ip),
        .id_rd_we    (bus.id_rd_we_ip),
        .id_is_load  (bus.id_is_load_ip),
        .hazard      (hazard)
    );

    always_comb begin
        mem_stuck = bus.mem_req_ip && !bus.mem_gnt_ip;
        state_d   = state_q;
        pend_d    = pend_q;
        stall     = '0;
        flush     = '0;
        advance   = 1'b0;
        ex_bubble = 1'b0;
        unique case (state_q)
            StRun: begin
                if (mem_stuck) begin
                    // MEM cannot complete: freeze everything already this cycle and
                    // park any redirect until the pipeline moves again.
                    state_d = StMemWait;
                    stall   = '1;
                    pend_d  = pend_q || bus.ex_redirect_ip;
                end else if (bus.ex_redirect_ip || pend_q) begin
                    // Redirect wins over a hazard: the ID instruction is wrong-path anyway.
                    flush[StgId] = 1'b1;
                    flush[StgEx] = 1'b1;
                    pend_d       = 1'b0;
                    advance      = 1'b1;
                    ex_bubble    = 1'b1;
                end else if (hazard) begin
                    stall[StgIf] = 1'b1;
                    stall[StgId] = 1'b1;
                    flush[StgEx] = 1'b1;
                    advance      = 1'b1;
                    ex_bubble    = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            StMemWait: begin
                // Grant cycle is still stalled; hazards are masked until back in RUN.
                stall  = '1;
                pend_d = pend_q || bus.ex_redirect_ip;
                if (bus.mem_gnt_ip) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
        if (reset) begin
            stall = '0;
            flush = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (|stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StRun;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall_op      = stall;
    assign bus.flush_op      = flush;
    assign bus.state_op      = reset ? StRun : state_q;
    assign bus.hazard_cnt_op = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int unsigned NS = 5;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 16;
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic          id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          ex_redirect, mem_req, mem_gnt;

    pipe_hazard_ctrl_if #(.NUM_STAGES(NS), .REG_AW(AW), .HCNT_W(CW)) bus0 ();
    pipe_hazard_ctrl_if #(.NUM_STAGES(NS), .REG_AW(AW), .HCNT_W(CW)) bus1 ();

    assign bus0.id_valid_ip    = id_valid;
    assign bus0.id_rs1_ip      = id_rs1;
    assign bus0.id_rs1_used_ip = id_rs1_used;
    assign bus0.id_rs2_ip      = id_rs2;
    assign bus0.id_rs2_used_ip = id_rs2_used;
    assign bus0.id_rd_ip       = id_rd;
    assign bus0.id_rd_we_ip    = id_rd_we;
    assign bus0.id_is_load_ip  = id_is_load;
    assign bus0.ex_redirect_ip = ex_redirect;
    assign bus0.mem_req_ip     = mem_req;
    assign bus0.mem_gnt_ip     = mem_gnt;
    assign bus1.id_valid_ip    = id_valid;
    assign bus1.id_rs1_ip      = id_rs1;
    assign bus1.id_rs1_used_ip = id_rs1_used;
    assign bus1.id_rs2_ip      = id_rs2;
    assign bus1.id_rs2_used_ip = id_rs2_used;
    assign bus1.id_rd_ip       = id_rd;
    assign bus1.id_rd_we_ip    = id_rd_we;
    assign bus1.id_is_load_ip  = id_is_load;
    assign bus1.ex_redirect_ip = ex_redirect;
    assign bus1.mem_req_ip     = mem_req;
    assign bus1.mem_gnt_ip     = mem_gnt;

    pipe_hazard_ctrl #(
        .NUM_STAGES (NS), .REG_AW (AW), .FWD_EN (1'b1), .MEM_STAGE (3), .HCNT_W (CW)
    ) dut_fwd (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    pipe_hazard_ctrl #(
        .NUM_STAGES (NS), .REG_AW (AW), .FWD_EN (1'b0), .MEM_STAGE (3), .HCNT_W (CW)
    ) dut_nofwd (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        bit          sel;
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic [1:0]  state;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: actual %0h required %0h", tag, what, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle against the selected DUT.
    always @(negedge clock) begin
        exp_t        e;
        logic [4:0]  st, fl;
        logic [1:0]  sv;
        logic [15:0] cv;
        if (q.size() > 0) begin
            e  = q.pop_front();
            st = e.sel ? bus1.stall_op      : bus0.stall_op;
            fl = e.sel ? bus1.flush_op      : bus0.flush_op;
            sv = e.sel ? bus1.state_op      : bus0.state_op;
            cv = e.sel ? bus1.hazard_cnt_op : bus0.hazard_cnt_op;
            chk(e.tag, "stall_op", 32'(st), 32'(e.stall));
            chk(e.tag, "flush_op", 32'(fl), 32'(e.flush));
            chk(e.tag, "state_op", 32'(sv), 32'(e.state));
            chk(e.tag, "hazard_cnt_op", 32'(cv), 32'(e.cnt));
        end
    end

    task automatic cyc(input bit sel, input logic [4:0] st, input logic [4:0] fl,
                       input logic [1:0] s, input logic [15:0] c, input string tag);
        exp_t e;
        e.sel = sel; e.stall = st; e.flush = fl; e.state = s; e.cnt = c; e.tag = tag;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs1 = '0; id_rs1_used = 1'b0; id_rs2 = '0; id_rs2_used = 1'b0;
        id_rd = '0; id_rd_we = 1'b0; id_is_load = 1'b0;
        ex_redirect = 1'b0; mem_req = 1'b0; mem_gnt = 1'b0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic we,
                          input logic ld);
        id_valid = 1'b1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_rd_we = we; id_is_load = ld;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset   = 1'b1;
        mem_req = 1'b1;
        @(posedge clock);
        #1;
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd0, "reset_fwd");
        cyc(1, 5'h00, 5'h00, S_RUN, 16'd0, "reset_nofwd");
        reset = 1'b0;

        // Load-use with forwarding: exactly one stall cycle.
        do_reset();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd0, "t1_lw");
        set_id(5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
        cyc(0, 5'b00011, 5'b00100, S_RUN, 16'd0, "t1_loaduse");
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd1, "t1_release");
        idle();
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd1, "t1_cnt");

        // No forwarding: stall while x7 is in EX, MEM and WB; x0 never hazards.
        do_reset();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        cyc(1, 5'h00, 5'h00, S_RUN, 16'd0, "t2_add");
        set_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        cyc(1, 5'b00011, 5'b00100, S_RUN, 16'd0, "t2_raw_ex");
        cyc(1, 5'b00011, 5'b00100, S_RUN, 16'd1, "t2_raw_mem");
        cyc(1, 5'b00011, 5'b00100, S_RUN, 16'd2, "t2_raw_wb");
        cyc(1, 5'h00, 5'h00, S_RUN, 16'd3, "t2_release");
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc(1, 5'h00, 5'h00, S_RUN, 16'd3, "t2_wr_x0");
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
        cyc(1, 5'h00, 5'h00, S_RUN, 16'd3, "t2_rd_x0");

        // Memory grant wait: 4 gnt-low cycles + grant cycle stalled, shadow frozen.
        do_reset();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd0, "t3_lw");
        set_id(5'd0, 1'b0, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0);
        mem_req = 1'b1;
        cyc(0, 5'h1F, 5'h00, S_RUN, 16'd0, "t3_req");
        cyc(0, 5'h1F, 5'h00, S_WAIT, 16'd1, "t3_wait1");
        cyc(0, 5'h1F, 5'h00, S_WAIT, 16'd2, "t3_wait2");
        cyc(0, 5'h1F, 5'h00, S_WAIT, 16'd3, "t3_wait3");
        mem_gnt = 1'b1;
        cyc(0, 5'h1F, 5'h00, S_WAIT, 16'd4, "t3_gnt");
        mem_req = 1'b0; mem_gnt = 1'b0;
        cyc(0, 5'b00011, 5'b00100, S_RUN, 16'd5, "t3_shadow_kept");
        idle();
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd6, "t3_after");

        // Redirect during MEM_WAIT is deferred and applied once.
        do_reset();
        mem_req = 1'b1;
        cyc(0, 5'h1F, 5'h00, S_RUN, 16'd0, "t4_req");
        ex_redirect = 1'b1;
        cyc(0, 5'h1F, 5'h00, S_WAIT, 16'd1, "t4_redir_in_wait");
        ex_redirect = 1'b0;
        cyc(0, 5'h1F, 5'h00, S_WAIT, 16'd2, "t4_wait");
        mem_gnt = 1'b1;
        cyc(0, 5'h1F, 5'h00, S_WAIT, 16'd3, "t4_gnt");
        mem_req = 1'b0; mem_gnt = 1'b0;
        cyc(0, 5'h00, 5'b00110, S_RUN, 16'd4, "t4_flush");
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd4, "t4_once");

        // Redirect beats a simultaneous load-use hazard.
        do_reset();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd0, "t5_lw");
        set_id(5'd0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
        ex_redirect = 1'b1;
        cyc(0, 5'h00, 5'b00110, S_RUN, 16'd0, "t5_redir_wins");
        ex_redirect = 1'b0;
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd0, "t5_after");

        // Invalid ID instruction raises no hazard and advances as a bubble.
        do_reset();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd0, "t7_lw");
        set_id(5'd4, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        id_valid = 1'b0;
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd0, "t7_invalid");
        id_valid = 1'b1;
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd0, "t7_bubble_passed");

        // Reset in MEM_WAIT with a pending redirect drops everything.
        do_reset();
        mem_req = 1'b1;
        cyc(0, 5'h1F, 5'h00, S_RUN, 16'd0, "t6_req");
        ex_redirect = 1'b1;
        cyc(0, 5'h1F, 5'h00, S_WAIT, 16'd1, "t6_redir");
        ex_redirect = 1'b0;
        reset = 1'b1;
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd2, "t6_reset_hi");
        reset = 1'b0; mem_req = 1'b0;
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd0, "t6_post_reset");
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd0, "t6_no_flush");
        cyc(0, 5'h00, 5'h00, S_RUN, 16'd0, "t6_no_flush2");

        // Counter saturation.
        mem_req = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            @(posedge clock);
            #1;
        end
        cyc(0, 5'h1F, 5'h00, S_WAIT, 16'hFFFE, "t6_sat_m1");
        cyc(0, 5'h1F, 5'h00, S_WAIT, 16'hFFFF, "t6_sat");
        cyc(0, 5'h1F, 5'h00, S_WAIT, 16'hFFFF, "t6_sat_hold");

        do_reset();
        @(posedge clock);
        #1;
        chk("drain", "pending expectations", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
